// File: rtl/vga_pattern_pkg.sv
// vga_pattern_pkg: shared mode encodings and elaboration-time helpers for the
// VGA timing / test-pattern generator (vga_pattern_gen, vga_pattern_colour).
package vga_pattern_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRID  = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Total length of one axis: visible + front porch + sync + back porch.
  function automatic int timing_total(input int vis, input int fp,
                                      input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  // Number of bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int width_of(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/vga_pattern_colour.sv
// vga_pattern_colour: combinational pattern generator. Maps a beam position,
// the frame's latched mode, the frame counter and the solid colour to RGB.
// Blanking is applied by the caller. Optional build macro
// VGA_PATTERN_SCROLL_EN makes bars and grid scroll one pixel per frame.
module vga_pattern_colour
  import vga_pattern_pkg::*;
#(
  parameter int C_bits    = 8,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int GRID_LOG2 = 4,
  parameter int XW        = 10,
  parameter int YW        = 10
) (
  input  logic [XW-1:0]       i_x,
  input  logic [YW-1:0]       i_y,
  input  logic [1:0]          i_mode,
  input  logic [7:0]          i_frame_cnt,
  input  logic [3*C_bits-1:0] i_solid_rgb,
  output logic [C_bits-1:0]   o_r,
  output logic [C_bits-1:0]   o_g,
  output logic [C_bits-1:0]   o_b
);

  localparam int BAR_W = H_VISIBLE / 8;
  localparam logic [XW-1:0] X_LAST = XW'(H_VISIBLE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_VISIBLE - 1);

  // Horizontal coordinate seen by the bars and grid patterns.
  logic [XW-1:0] w_x;

`ifdef VGA_PATTERN_SCROLL_EN
  // One spare bit above the wider operand keeps the sum from overflowing.
  localparam int SW = ((XW > 8) ? XW : 8) + 1;
  logic [SW-1:0] w_sum;
  assign w_sum = SW'(i_x) + SW'(i_frame_cnt);
  assign w_x   = XW'(w_sum % SW'(H_VISIBLE));
`else
  assign w_x = i_x;
`endif

  // Bar index, clamped so a width that is not a multiple of 8 stays on bar 7.
  logic [XW-1:0] w_bar_q;
  logic [2:0]    w_bar;
  assign w_bar_q = w_x / XW'(BAR_W);
  assign w_bar   = (w_bar_q > XW'(7)) ? 3'd7 : w_bar_q[2:0];

  // Grid lines on every pitch boundary plus the right and bottom edges.
  logic w_grid_on;
  assign w_grid_on = (w_x[GRID_LOG2-1:0] == '0) || (i_y[GRID_LOG2-1:0] == '0) ||
                     (w_x == X_LAST) || (i_y == Y_LAST);

  // Select the colour of the current pixel for the latched mode.
  always_comb begin
    o_r = '0;
    o_g = '0;
    o_b = '0;
    case (i_mode)
      MODE_BARS: begin
        o_r = {C_bits{~w_bar[1]}};
        o_g = {C_bits{~w_bar[2]}};
        o_b = {C_bits{~w_bar[0]}};
      end
      MODE_GRID: begin
        o_r = {C_bits{w_grid_on}};
        o_g = {C_bits{w_grid_on}};
        o_b = {C_bits{w_grid_on}};
      end
      MODE_GRAD: begin
        o_r = C_bits'(i_x);
        o_g = C_bits'(i_y);
        o_b = C_bits'(i_frame_cnt);
      end
      default: begin
        o_r = i_solid_rgb[3*C_bits-1:2*C_bits];
        o_g = i_solid_rgb[2*C_bits-1:C_bits];
        o_b = i_solid_rgb[C_bits-1:0];
      end
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and test-pattern source. Owns the
// beam counters, sync generation, per-frame mode latch, frame counter and the
// output register stage; all outputs appear one clock after the counter state
// that produced them. Optional build macro VGA_PATTERN_SCROLL_EN (handled in
// vga_pattern_colour) scrolls the bars and grid patterns.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int C_bits    = 8,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int GRID_LOG2 = 4,
  localparam int H_TOTAL  = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP),
  localparam int XW       = width_of(H_TOTAL),
  localparam int YW       = width_of(V_TOTAL)
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [3*C_bits-1:0] solid_rgb,
  output logic [C_bits-1:0]   vga_r,
  output logic [C_bits-1:0]   vga_g,
  output logic [C_bits-1:0]   vga_b,
  output logic                vga_hsync,
  output logic                vga_vsync,
  output logic                vga_blank,
  output logic [XW-1:0]       beam_x,
  output logic [YW-1:0]       beam_y,
  output logic                frame_start
);

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_VISIBLE);
  localparam logic [XW-1:0] H_SS   = XW'(H_VISIBLE + H_FP);
  localparam logic [XW-1:0] H_SE   = XW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_VISIBLE);
  localparam logic [YW-1:0] V_SS   = YW'(V_VISIBLE + V_FP);
  localparam logic [YW-1:0] V_SE   = YW'(V_VISIBLE + V_FP + V_SYNC - 1);

  if ((H_VISIBLE / 8) == 0 || H_SYNC == 0 || V_SYNC == 0 ||
      H_VISIBLE == 0 || V_VISIBLE == 0) begin : g_bad_cfg
    $error("vga_pattern_gen: H_VISIBLE must be >= 8 and H_SYNC, V_SYNC, V_VISIBLE non-zero");
  end

  logic [XW-1:0]       r_hcnt;
  logic [YW-1:0]       r_vcnt;
  logic [7:0]          r_frame_cnt;
  logic [1:0]          r_cur_mode;

  logic [3*C_bits-1:0] r_rgb;
  logic                r_blank;
  logic                r_hsync;
  logic                r_vsync;
  logic [XW-1:0]       r_beam_x;
  logic [YW-1:0]       r_beam_y;
  logic                r_frame_start;

  logic                w_h_wrap;
  logic                w_f_wrap;
  logic                w_active;
  logic                w_hs_on;
  logic                w_vs_on;
  logic [C_bits-1:0]   w_r;
  logic [C_bits-1:0]   w_g;
  logic [C_bits-1:0]   w_b;

  assign w_h_wrap = (r_hcnt == H_LAST);
  assign w_f_wrap = w_h_wrap && (r_vcnt == V_LAST);
  assign w_active = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_on  = (r_hcnt >= H_SS) && (r_hcnt <= H_SE);
  assign w_vs_on  = (r_vcnt >= V_SS) && (r_vcnt <= V_SE);

  // Beam counters: hcnt every clock, vcnt once per line.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_wrap) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + YW'(1);
    end else begin
      r_hcnt <= r_hcnt + XW'(1);
    end
  end

  // Per-frame state: mode and frame count only change on the last pixel of a frame.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_cur_mode  <= MODE_BARS;
      r_frame_cnt <= '0;
    end else if (w_f_wrap) begin
      r_cur_mode  <= mode;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  vga_pattern_colour #(
    .C_bits    (C_bits),
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE),
    .GRID_LOG2 (GRID_LOG2),
    .XW        (XW),
    .YW        (YW)
  ) u_colour (
    .i_x         (r_hcnt),
    .i_y         (r_vcnt),
    .i_mode      (r_cur_mode),
    .i_frame_cnt (r_frame_cnt),
    .i_solid_rgb (solid_rgb),
    .o_r         (w_r),
    .o_g         (w_g),
    .o_b         (w_b)
  );

  // Output stage: every output is registered from the same counter state.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_rgb         <= '0;
      r_blank       <= 1'b1;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_beam_x      <= '0;
      r_beam_y      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= w_active ? {w_r, w_g, w_b} : '0;
      r_blank       <= ~w_active;
      r_hsync       <= w_hs_on ? H_POL : ~H_POL;
      r_vsync       <= w_vs_on ? V_POL : ~V_POL;
      r_beam_x      <= r_hcnt;
      r_beam_y      <= r_vcnt;
      r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  assign vga_r       = r_rgb[3*C_bits-1:2*C_bits];
  assign vga_g       = r_rgb[2*C_bits-1:C_bits];
  assign vga_b       = r_rgb[C_bits-1:0];
  assign vga_blank   = r_blank;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign beam_x      = r_beam_x;
  assign beam_y      = r_beam_y;
  assign frame_start = r_frame_start;

endmodule
